// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
//   Shared types and constants for the multicycle controller: FSM state
//   enum, IR opcode values, and the Pc_src / Alu_b_sel / Alu_op encodings.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD,
      MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT
   } state_t;

   localparam logic [3:0] OP_ALU_R = 4'd0;
   localparam logic [3:0] OP_ALU_I = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_STORE = 4'd3;
   localparam logic [3:0] OP_BEQ   = 4'd4;
   localparam logic [3:0] OP_JUMP  = 4'd5;
   localparam logic [3:0] OP_HALT  = 4'd15;

   typedef enum logic [1:0] {
      PC_SRC_ALU    = 2'd0,
      PC_SRC_ALUOUT = 2'd1,
      PC_SRC_JUMP   = 2'd2
   } pc_src_t;

   typedef enum logic [1:0] {
      ALU_B_REG     = 2'd0,
      ALU_B_FOUR    = 2'd1,
      ALU_B_IMM     = 2'd2,
      ALU_B_IMM_SL2 = 2'd3
   } alu_b_sel_t;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'd0,
      ALU_OP_SUB   = 2'd1,
      ALU_OP_FUNCT = 2'd2
   } alu_op_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Memory handshake bundle between the controller and memory.
//   Mem_req : request strobe (controller -> memory)
//   Mem_we  : write qualifier for Mem_req
//   Iord    : address select, 0 PC / 1 ALUOut
//   Mem_ack : completion strobe (memory -> controller)
interface multicycle_control_if;
   logic Mem_req;
   logic Mem_we;
   logic Iord;
   logic Mem_ack;

   modport master (output Mem_req, Mem_we, Iord, input Mem_ack);
   modport slave  (input Mem_req, Mem_we, Iord, output Mem_ack);
endinterface

// File: rtl/mc_mem_timeout.sv
// mc_mem_timeout
//   Counts cycles a memory request waits without an ack and flags a
//   timeout when MEM_TIMEOUT wait cycles have already elapsed and the
//   current cycle is still unacked (an ack in that cycle wins).
//   clk, rst_n  : clock, async active-low reset
//   req_i       : request currently outstanding
//   ack_i       : memory ack
//   restart_i   : FSM is changing state this cycle
//   timeout_o   : wait limit hit with no ack this cycle
module mc_mem_timeout #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_i,
   input  logic ack_i,
   input  logic restart_i,
   output logic timeout_o
);

   localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (!req_i || ack_i || restart_i) cnt_d = '0;
   end

   assign timeout_o = req_i && !ack_i && (cnt_q == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle CPU control FSM with memory wait timeout.
//   Optional feature: define MC_PERF_COUNTERS_EN to add Cycle_cnt and
//   Retire_cnt performance counters.
//   clk, rst_n        : clock, async active-low reset
//   Opcode, Zero      : IR opcode, ALU zero flag
//   mem (master)      : Mem_req / Mem_we / Iord / Mem_ack handshake
//   Ir_we, Pc_we, Reg_we, Mem_to_reg, Pc_src, Alu_a_sel, Alu_b_sel,
//   Alu_op            : datapath controls
//   Halted, Illegal, Bus_err : status (Illegal, Bus_err sticky)
//   Cycle_cnt, Retire_cnt    : perf counters (MC_PERF_COUNTERS_EN only)
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  Opcode,
   input  logic        Zero,
   multicycle_control_if.master mem,
   output logic        Ir_we,
   output logic        Pc_we,
   output logic        Reg_we,
   output logic        Mem_to_reg,
   output logic [1:0]  Pc_src,
   output logic        Alu_a_sel,
   output logic [1:0]  Alu_b_sel,
   output logic [1:0]  Alu_op,
   output logic        Halted,
   output logic        Illegal,
   output logic        Bus_err
`ifdef MC_PERF_COUNTERS_EN
   ,
   output logic [31:0] Cycle_cnt,
   output logic [31:0] Retire_cnt
`endif
);

   state_t state_q, state_d;
   logic   illegal_q, bus_err_q;
   logic   mem_busy, timeout, set_illegal;
   logic   req, we, iord, ir_we, pc_we, reg_we, halted;

   // Request is a pure function of state so the timeout compare does not
   // loop back through the next-state logic.
   assign mem_busy = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

   mc_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (mem_busy),
      .ack_i     (mem.Mem_ack),
      .restart_i (state_d != state_q),
      .timeout_o (timeout)
   );

   always_comb begin
      state_d     = state_q;
      req         = 1'b0;
      we          = 1'b0;
      iord        = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      reg_we      = 1'b0;
      halted      = 1'b0;
      set_illegal = 1'b0;
      Mem_to_reg  = 1'b0;
      Pc_src      = PC_SRC_ALU;
      Alu_a_sel   = 1'b0;
      Alu_b_sel   = ALU_B_REG;
      Alu_op      = ALU_OP_ADD;
      case (state_q)
         FETCH: begin
            req       = 1'b1;
            Alu_b_sel = ALU_B_FOUR;
            if (timeout) state_d = HALT;
            else if (mem.Mem_ack) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            Alu_b_sel = ALU_B_IMM_SL2;
            case (Opcode)
               OP_ALU_R:          state_d = EXEC_R;
               OP_ALU_I:          state_d = EXEC_I;
               OP_LOAD, OP_STORE: state_d = MEM_ADDR;
               OP_BEQ:            state_d = BRANCH;
               OP_JUMP:           state_d = JUMP;
               OP_HALT:           state_d = HALT;
               default: begin
                  set_illegal = 1'b1;
                  state_d     = HALT;
               end
            endcase
         end
         EXEC_R: begin
            Alu_a_sel = 1'b1;
            Alu_op    = ALU_OP_FUNCT;
            state_d   = WB_ALU;
         end
         EXEC_I: begin
            Alu_a_sel = 1'b1;
            Alu_b_sel = ALU_B_IMM;
            state_d   = WB_ALU;
         end
         MEM_ADDR: begin
            Alu_a_sel = 1'b1;
            Alu_b_sel = ALU_B_IMM;
            state_d   = (Opcode == OP_STORE) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            req  = 1'b1;
            iord = 1'b1;
            if (timeout)          state_d = HALT;
            else if (mem.Mem_ack) state_d = WB_MEM;
         end
         MEM_WR: begin
            req  = 1'b1;
            we   = 1'b1;
            iord = 1'b1;
            if (timeout)          state_d = HALT;
            else if (mem.Mem_ack) state_d = FETCH;
         end
         WB_ALU: begin
            reg_we  = 1'b1;
            state_d = FETCH;
         end
         WB_MEM: begin
            reg_we     = 1'b1;
            Mem_to_reg = 1'b1;
            state_d    = FETCH;
         end
         BRANCH: begin
            Alu_a_sel = 1'b1;
            Alu_op    = ALU_OP_SUB;
            Pc_src    = PC_SRC_ALUOUT;
            pc_we     = Zero;
            state_d   = FETCH;
         end
         JUMP: begin
            Pc_src  = PC_SRC_JUMP;
            pc_we   = 1'b1;
            state_d = FETCH;
         end
         HALT:    halted  = 1'b1;
         default: state_d = FETCH;
      endcase
   end

   // Reset parks the FSM in FETCH, which would otherwise request memory;
   // gating with rst_n keeps the bus and enables quiet while reset is held.
   assign mem.Mem_req = req & rst_n;
   assign mem.Mem_we  = we & rst_n;
   assign mem.Iord    = iord;
   assign Ir_we       = ir_we & rst_n;
   assign Pc_we       = pc_we & rst_n;
   assign Reg_we      = reg_we & rst_n;
   assign Halted      = halted & rst_n;
   assign Illegal     = illegal_q;
   assign Bus_err     = bus_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (set_illegal) illegal_q <= 1'b1;
         if (timeout)     bus_err_q <= 1'b1;
      end
   end

`ifdef MC_PERF_COUNTERS_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d, retire_cnt_q, retire_cnt_d;

   always_comb begin
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (state_q != HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (state_d == FETCH && state_q != FETCH) retire_cnt_d = retire_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign Cycle_cnt  = cycle_cnt_q;
   assign Retire_cnt = retire_cnt_q;
`endif

endmodule
